// File: rtl/alarm_bank.sv
// Multi-channel alarm controller; `ALARM_SNOOZE_EN enables the snooze state and input.
// Latency: writes, fires and dismissals show on outputs one cycle after the causing edge.
// Backpressure: none; all inputs are accepted every cycle, outputs are registered.
module alarm_bank #(
   parameter int N_CH       = 4,
   parameter int TIME_W     = 15,
   parameter int DUR_W      = 4,
   parameter int SNOOZE_MIN = 5,
   localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [TIME_W-1:0] cur_time,
   input  logic              min_tick,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [TIME_W-1:0] wr_time,
   input  logic [DUR_W-1:0]  wr_dur,
   input  logic              wr_arm,
   input  logic              off_alarm,
   input  logic              snooze,
   output logic              alarm,
   output logic [N_CH-1:0]   ring_vec,
   output logic [N_CH-1:0]   armed_vec
);

   typedef enum logic [1:0] {DISARMED, ARMED, RINGING, SNOOZED} ch_state_t;

   logic [N_CH-1:0] ring_nxt;
   logic [N_CH-1:0] armed_nxt;

`ifndef ALARM_SNOOZE_EN
   logic unused_snooze_cfg;
   assign unused_snooze_cfg = ^{snooze, DUR_W'(SNOOZE_MIN)};
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      ch_state_t         st_q, st_d;
      logic [TIME_W-1:0] tm_q, tm_d;
      logic [DUR_W-1:0]  dur_q, dur_d;
      logic [DUR_W-1:0]  rem_q, rem_d;
      logic              wr_hit;
      logic [DUR_W-1:0]  rem_dec;

      // Out-of-range indices never compare equal, so such writes fall through.
      assign wr_hit  = wr_en && (wr_ch == CH_W'(i));
      assign rem_dec = (rem_q == '0) ? rem_q : rem_q - 1'b1;

      always_comb begin
         st_d  = st_q;
         tm_d  = tm_q;
         dur_d = dur_q;
         rem_d = rem_q;
         if (wr_hit) begin
            tm_d  = wr_time;
            dur_d = wr_dur;
            st_d  = wr_arm ? ARMED : DISARMED;
         end else begin
            case (st_q)
               ARMED: begin
                  if (min_tick && (cur_time == tm_q) && !off_alarm) begin
                     st_d  = RINGING;
                     rem_d = dur_q;
                  end
               end
               RINGING: begin
                  if (off_alarm) begin
                     st_d = ARMED;
                  end
`ifdef ALARM_SNOOZE_EN
                  else if (snooze) begin
                     st_d  = SNOOZED;
                     rem_d = DUR_W'(SNOOZE_MIN);
                  end
`endif
                  else if (min_tick && (dur_q != '0)) begin
                     rem_d = rem_dec;
                     if (rem_q == DUR_W'(1)) st_d = ARMED;
                  end
               end
`ifdef ALARM_SNOOZE_EN
               SNOOZED: begin
                  if (off_alarm) begin
                     st_d = ARMED;
                  end else if (min_tick) begin
                     rem_d = rem_dec;
                     if (rem_q == DUR_W'(1)) begin
                        st_d  = RINGING;
                        rem_d = dur_q;
                     end
                  end
               end
`endif
               default: st_d = st_q;
            endcase
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            st_q  <= DISARMED;
            tm_q  <= '0;
            dur_q <= '0;
            rem_q <= '0;
         end else begin
            st_q  <= st_d;
            tm_q  <= tm_d;
            dur_q <= dur_d;
            rem_q <= rem_d;
         end
      end

      assign ring_nxt[i]  = (st_d == RINGING);
      assign armed_nxt[i] = (st_d != DISARMED);
   end

   // Outputs are registered copies of the next state so no input reaches a port combinationally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ring_vec  <= '0;
         armed_vec <= '0;
         alarm     <= 1'b0;
      end else begin
         ring_vec  <= ring_nxt;
         armed_vec <= armed_nxt;
         alarm     <= |ring_nxt;
      end
   end

endmodule

// File: tb/tb_alarm_bank.sv
// Bench for alarm_bank: vector table with scoreboard, plus reset and out-of-range sequences.
module tb_alarm_bank;

`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ = 1'b1;
`else
   localparam bit SNZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [14:0] cur_time;
   logic        min_tick;
   logic        wr_en;
   logic [1:0]  wr_ch;
   logic [14:0] wr_time;
   logic [3:0]  wr_dur;
   logic        wr_arm;
   logic        off_alarm;
   logic        snooze;
   logic        alarm;
   logic [3:0]  ring_vec;
   logic [3:0]  armed_vec;
   logic        alarm3;
   logic [2:0]  ring_vec3;
   logic [2:0]  armed_vec3;

   always #5 clk = ~clk;

   alarm_bank #(.N_CH(4), .TIME_W(15), .DUR_W(4), .SNOOZE_MIN(5)) dut (
      .clk(clk), .reset_n(reset_n), .cur_time(cur_time), .min_tick(min_tick),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_time(wr_time), .wr_dur(wr_dur), .wr_arm(wr_arm),
      .off_alarm(off_alarm), .snooze(snooze),
      .alarm(alarm), .ring_vec(ring_vec), .armed_vec(armed_vec)
   );

   alarm_bank #(.N_CH(3), .TIME_W(15), .DUR_W(4), .SNOOZE_MIN(5)) dut3 (
      .clk(clk), .reset_n(reset_n), .cur_time(cur_time), .min_tick(min_tick),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_time(wr_time), .wr_dur(wr_dur), .wr_arm(wr_arm),
      .off_alarm(off_alarm), .snooze(snooze),
      .alarm(alarm3), .ring_vec(ring_vec3), .armed_vec(armed_vec3)
   );

   typedef struct {
      logic        tick;
      logic [14:0] t;
      logic        wr;
      logic [1:0]  ch;
      logic [14:0] wt;
      logic [3:0]  wd;
      logic        wa;
      logic        off;
      logic        snz;
      logic [3:0]  ring;
      logic [3:0]  armed;
   } vec_t;

   vec_t        tbl[$];
   logic [8:0]  exp_q[$];
   int          n_vec = 0;
   int          n_bad = 0;

   function automatic vec_t mk(input logic tick, input logic [14:0] t, input logic wr,
                               input logic [1:0] ch, input logic [14:0] wt, input logic [3:0] wd,
                               input logic wa, input logic off, input logic snz,
                               input logic [3:0] ring, input logic [3:0] armed);
      vec_t v;
      v.tick = tick; v.t = t; v.wr = wr; v.ch = ch; v.wt = wt; v.wd = wd; v.wa = wa;
      v.off = off; v.snz = snz; v.ring = ring; v.armed = armed;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      min_tick = 1'b0; wr_en = 1'b0; wr_ch = 2'd0; wr_time = '0; wr_dur = '0;
      wr_arm = 1'b0; off_alarm = 1'b0; snooze = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick(input logic [14:0] t);
      idle(); min_tick = 1'b1; cur_time = t;
      cyc();
      idle();
   endtask

   task automatic do_wr(input logic [1:0] ch, input logic [14:0] t, input logic [3:0] d, input logic a);
      idle(); wr_en = 1'b1; wr_ch = ch; wr_time = t; wr_dur = d; wr_arm = a;
      cyc();
      idle();
   endtask

   initial begin
      // Basic fire and expire on ch0
      tbl.push_back(mk(0, 15'h0000, 1, 0, 15'h0A1E, 2, 1, 0, 0, 4'b0000, 4'b0001));
      tbl.push_back(mk(1, 15'h0A1E, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 4'b0001));
      tbl.push_back(mk(0, 15'h0A1E, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 4'b0001));
      tbl.push_back(mk(1, 15'h0A1F, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 4'b0001));
      tbl.push_back(mk(1, 15'h0A20, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0001));
      // Overlapping ch1 (hold) and ch2 (one minute)
      tbl.push_back(mk(0, 15'h0A20, 1, 1, 15'h0100, 0, 1, 0, 0, 4'b0000, 4'b0011));
      tbl.push_back(mk(0, 15'h0A20, 1, 2, 15'h0100, 1, 1, 0, 0, 4'b0000, 4'b0111));
      tbl.push_back(mk(1, 15'h0100, 0, 0, 0, 0, 0, 0, 0, 4'b0110, 4'b0111));
      tbl.push_back(mk(1, 15'h0101, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 4'b0111));
      tbl.push_back(mk(0, 15'h0101, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0111));
      // Write on the matching tick cancels; off held blocks a fire
      tbl.push_back(mk(0, 15'h0101, 1, 3, 15'h0200, 1, 1, 0, 0, 4'b0000, 4'b1111));
      tbl.push_back(mk(1, 15'h0200, 1, 3, 15'h0200, 1, 1, 0, 0, 4'b0000, 4'b1111));
      tbl.push_back(mk(1, 15'h0A1E, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b1111));
      tbl.push_back(mk(1, 15'h0A1E, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 4'b1111));
      tbl.push_back(mk(1, 15'h0200, 0, 0, 0, 0, 0, 0, 0, 4'b1001, 4'b1111));
      tbl.push_back(mk(0, 15'h0200, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b1111));
      // Disarm ch0 then match
      tbl.push_back(mk(0, 15'h0200, 1, 0, 15'h0A1E, 2, 0, 0, 0, 4'b0000, 4'b1110));
      tbl.push_back(mk(1, 15'h0A1E, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1110));
      // dur=0 keeps ringing across ticks; a write silences it
      tbl.push_back(mk(1, 15'h0100, 0, 0, 0, 0, 0, 0, 0, 4'b0110, 4'b1110));
      tbl.push_back(mk(1, 15'h0005, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 4'b1110));
      tbl.push_back(mk(1, 15'h0006, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 4'b1110));
      tbl.push_back(mk(0, 15'h0006, 1, 1, 15'h0100, 0, 1, 0, 0, 4'b0000, 4'b1110));
      // Snooze on ch0 with dur=3
      tbl.push_back(mk(0, 15'h0006, 1, 0, 15'h0300, 3, 1, 0, 0, 4'b0000, 4'b1111));
      tbl.push_back(mk(1, 15'h0300, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 4'b1111));
      tbl.push_back(mk(0, 15'h0300, 0, 0, 0, 0, 0, 0, 1, SNZ ? 4'b0000 : 4'b0001, 4'b1111));
      tbl.push_back(mk(1, 15'h0301, 0, 0, 0, 0, 0, 0, 0, SNZ ? 4'b0000 : 4'b0001, 4'b1111));
      tbl.push_back(mk(1, 15'h0302, 0, 0, 0, 0, 0, 0, 0, SNZ ? 4'b0000 : 4'b0001, 4'b1111));
      tbl.push_back(mk(1, 15'h0303, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111));
      tbl.push_back(mk(1, 15'h0304, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111));
      tbl.push_back(mk(1, 15'h0305, 0, 0, 0, 0, 0, 0, 0, SNZ ? 4'b0001 : 4'b0000, 4'b1111));
      tbl.push_back(mk(1, 15'h0306, 0, 0, 0, 0, 0, 0, 0, SNZ ? 4'b0001 : 4'b0000, 4'b1111));
      tbl.push_back(mk(1, 15'h0307, 0, 0, 0, 0, 0, 0, 0, SNZ ? 4'b0001 : 4'b0000, 4'b1111));
      tbl.push_back(mk(1, 15'h0308, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111));

      reset_n = 1'b0;
      cur_time = '0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("reset", {23'd0, alarm, armed_vec, ring_vec}, 32'd0);
      chk("reset_n3", {25'd0, alarm3, armed_vec3, ring_vec3}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc();

      foreach (tbl[i]) begin
         min_tick = tbl[i].tick; cur_time = tbl[i].t; wr_en = tbl[i].wr; wr_ch = tbl[i].ch;
         wr_time = tbl[i].wt; wr_dur = tbl[i].wd; wr_arm = tbl[i].wa;
         off_alarm = tbl[i].off; snooze = tbl[i].snz;
         exp_q.push_back({|tbl[i].ring, tbl[i].armed, tbl[i].ring});
         cyc();
         if (exp_q.size() == 0) chk($sformatf("vec%0d_sb", i), 32'd0, 32'd1);
         else chk($sformatf("vec%0d", i), {23'd0, alarm, armed_vec, ring_vec}, {23'd0, exp_q.pop_front()});
      end
      idle();

      // Mid-operation reset while ch1 and ch2 ring
      do_wr(2'd1, 15'h0100, 4'd0, 1'b1);
      do_wr(2'd2, 15'h0100, 4'd3, 1'b1);
      do_tick(15'h0100);
      chk("two_ring", {28'd0, ring_vec}, 32'h6);
      #3 reset_n = 1'b0;
      #1;
      chk("async_reset", {23'd0, alarm, armed_vec, ring_vec}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      do_tick(15'h0100);
      chk("no_refire_after_reset", {23'd0, alarm, armed_vec, ring_vec}, 32'd0);

      // Out-of-range channel on the 3-channel instance
      do_wr(2'd3, 15'h0400, 4'd1, 1'b1);
      chk("oor_armed3", {29'd0, armed_vec3}, 32'd0);
      chk("oor_armed4", {28'd0, armed_vec}, 32'h8);
      do_tick(15'h0400);
      chk("oor_ring3", {28'd0, alarm3, ring_vec3}, 32'd0);
      chk("ch3_ring4", {28'd0, ring_vec}, 32'h8);
      do_wr(2'd2, 15'h0400, 4'd1, 1'b1);
      chk("inrange_armed3", {29'd0, armed_vec3}, 32'h4);
      do_tick(15'h0400);
      chk("inrange_ring3", {28'd0, alarm3, ring_vec3}, 32'hC);
      do_tick(15'h0401);
      chk("inrange_expire3", {28'd0, alarm3, ring_vec3}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alarm_bank.md
# alarm_bank

Multi-channel alarm controller that replaces the single-alarm block in the clock design. Holds `N_CH` independently programmable alarm times. On each minute tick it compares every armed channel against the current time, then rings matching channels for a programmable number of minutes or until dismissed. A global `alarm` output drives the buzzer path, and per-channel status vectors feed the display logic.

## Interface

**Parameters**
- `N_CH`, 4: number of alarm channels (1..16).
- `TIME_W`, 15: width of a packed time-of-day word (same packing as `cur_time[14:0]`).
- `DUR_W`, 4: width of per-channel ring duration, in minutes.
- `SNOOZE_MIN`, 5: snooze interval in minutes (1..2^DUR_W-1); used only with `ALARM_SNOOZE_EN`.

**Ports**
- `clk`, in, 1: system clock; all state updates on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cur_time`, in, TIME_W: current time of day, stable around `min_tick`.
- `min_tick`, in, 1: single-cycle pulse, synchronous to `clk`, once per minute after `cur_time` updates.
- `wr_en`, in, 1: program channel `wr_ch` this cycle.
- `wr_ch`, in, clog2(N_CH): channel index; out-of-range writes are ignored.
- `wr_time`, in, TIME_W: alarm time for the written channel.
- `wr_dur`, in, DUR_W: ring duration in minutes; 0 means ring until `off_alarm`.
- `wr_arm`, in, 1: 1 arms the channel, 0 disarms it.
- `off_alarm`, in, 1: level; silences every ringing or snoozed channel.
- `snooze`, in, 1: level; snoozes every ringing channel. Ignored without the macro.
- `alarm`, out, 1: OR of `ring_vec`.
- `ring_vec`, out, N_CH: channel is RINGING.
- `armed_vec`, out, N_CH: channel is not DISARMED.

## Operation

Each channel has registers `time`, `dur` and `remain` (DUR_W bits), plus a state.

**States**
- **DISARMED**
  - `wr_en` with `wr_arm=1` → ARMED.
- **ARMED**
  - `min_tick` with `cur_time==time` → RINGING; loads `remain<=dur`.
  - `wr_en` with `wr_arm=0` → DISARMED.
- **RINGING**
  - `off_alarm` → ARMED.
  - `snooze` (macro only) → SNOOZED; loads `remain<=SNOOZE_MIN`.
  - `min_tick` with `dur!=0`: `remain<=remain-1`; if `remain==1` → ARMED.
- **SNOOZED**
  - `off_alarm` → ARMED.
  - `min_tick`: `remain<=remain-1`; if `remain==1` → RINGING with `remain<=dur`.

**Priority per channel, highest first:** reset, write to this channel, `off_alarm`, `snooze`, `min_tick`.

**Write rules**
- A write replaces `time` and `dur` and sets the state to ARMED or DISARMED.
- A write to a RINGING or SNOOZED channel silences it.
- A write cancels any match on the same cycle.

**Other rules**
- Matches are evaluated only on `min_tick`, so an alarm fires at most once per matching minute.
- An ARMED channel that matches while `off_alarm` is high stays ARMED and does not fire.
- Channels are fully independent: several may ring at once, and `alarm` stays high while any channel rings.
- Ringing channels remain armed afterwards and fire again the next time the time matches.
- Decrements saturate at 0; `remain` never wraps.

## Timing

- **Reset:** every channel DISARMED, `time=0`, `dur=0`, `remain=0`. `alarm=0`, `ring_vec=0`, `armed_vec=0`.
- **Write latency:** a write is visible in `armed_vec` on the cycle after `wr_en`.
- **Fire latency:** `ring_vec` bit and `alarm` rise on the cycle after the matching `min_tick`. The firing tick itself does not decrement `remain`.
- **Ring length:** a channel fired at tick T with `dur=D` (D≥1) clears on the cycle after tick T+D. It rings for exactly D minutes.
- **Dismiss latency:** `off_alarm` and `snooze` take effect on the next edge. No edge detection is applied, so a held level keeps the channels silenced.
- **Mid-operation reset:** asserting `reset_n` low clears all outputs asynchronously, within the same cycle.
- **Outputs:** all outputs derive from registers only; there is no combinational path from any input.

## Configuration

- **`ALARM_SNOOZE_EN`**, defined: SNOOZED state and `snooze` input are active as described above.
- **`ALARM_SNOOZE_EN`**, undefined:
  - `snooze` is ignored and the SNOOZED state does not exist.
  - `SNOOZE_MIN` is unused.
  - RINGING leaves only via `off_alarm`, duration expiry, write or reset.

## Test plan

- **Basic fire and expire:** reset; program ch0 `time=0x0A1E`, `dur=2`, armed; tick `cur_time=0x0A1E`.
  - → `ring_vec=0001` and `alarm=1` on the next cycle.
  - → Still ringing after tick +1; cleared after tick +2; `armed_vec[0]=1`.
- **Overlapping channels:** ch1 `dur=0` and ch2 `dur=1`, same time; fire both.
  - → `ring_vec=0110` after the tick.
  - → `0010` after the next tick; `off_alarm` pulse then gives `0000`.
- **Simultaneous events:**
  - Write to ch3 on the same cycle as its matching tick → ch3 does not ring.
  - `off_alarm` held during a matching tick on ch0 → no fire.
- **Snooze (`ALARM_SNOOZE_EN`, `SNOOZE_MIN=5`):** ch0 ringing with `dur=3`; pulse `snooze`.
  - → `ring_vec[0]=0` on the next cycle.
  - → Rings again after the 5th tick, then runs 3 minutes.
  - → Without the macro, the same stimulus leaves ch0 ringing.
- **Reset and disarm:**
  - `reset_n` low while two channels ring → all outputs 0 immediately; re-firing requires reprogramming.
  - Disarmed ch0 with matching time → no fire.
  - Write with `wr_ch≥N_CH` → no state change.
